// File: rtl/regfile_read_port.sv
// RV32I integer register file: one-hot write port, two registered read ports with write->read bypass.
// Optional debug read port enabled by defining RF_DBG_PORT_EN.
module regfile_read_port #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] choose_reg,
    input  logic [XLEN-1:0] wright_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            wr_err
`ifdef RF_DBG_PORT_EN
    ,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
`endif
);

    logic [XLEN-1:0] regs [NREG];
    logic            multi_hot;
    logic [NREG-1:0] wr_en;
    logic [XLEN-1:0] rs1_next;
    logic [XLEN-1:0] rs2_next;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_hot = |(choose_reg & (choose_reg - NREG'(1)));

    always_comb begin
        wr_en    = multi_hot ? '0 : choose_reg;
        wr_en[0] = 1'b0;
    end

    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        if (rs1_addr != '0)
            rs1_next = wr_en[rs1_addr] ? wright_data : regs[rs1_addr];
        if (rs2_addr != '0)
            rs2_next = wr_en[rs2_addr] ? wright_data : regs[rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++)
                regs[k] <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            for (int k = 1; k < NREG; k++)
                if (wr_en[k])
                    regs[k] <= wright_data;
            rd_valid <= rd_en;
            if (rd_en) begin
                rs1_data <= rs1_next;
                rs2_data <= rs2_next;
            end
            if (multi_hot)
                wr_err <= 1'b1;
        end
    end

`ifdef RF_DBG_PORT_EN
    // Raw storage view: sees only committed writes, never the bypass path.
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed self-checking bench for regfile_read_port.
module tb_regfile_read_port;

    logic        clk;
    logic        rst;
    logic [31:0] choose_reg;
    logic [31:0] wright_data;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;
    logic        wr_err;
`ifdef RF_DBG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    regfile_read_port dut (
        .clk         (clk),
        .rst         (rst),
        .choose_reg  (choose_reg),
        .wright_data (wright_data),
        .rd_en       (rd_en),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_valid    (rd_valid),
        .wr_err      (wr_err)
`ifdef RF_DBG_PORT_EN
        ,
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; inputs are then changed for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] sel, input logic [31:0] data,
                         input logic re, input logic [4:0] a1, input logic [4:0] a2);
        choose_reg  = sel;
        wright_data = data;
        rd_en       = re;
        rs1_addr    = a1;
        rs2_addr    = a2;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
`ifdef RF_DBG_PORT_EN
        dbg_addr = 5'd0;
`endif
        step();
        step();
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_err", 32'(wr_err), 32'h0);

        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 5'd5, 5'd31);
        step();
        check("t1_rs1", rs1_data, 32'h0);
        check("t1_rs2", rs2_data, 32'h0);
        check("t1_valid", 32'(rd_valid), 32'h1);

        drive(32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        step();
        check("t2_novalid", 32'(rd_valid), 32'h0);
        drive(32'h0, 32'h0, 1'b1, 5'd5, 5'd0);
        step();
        check("t2_rs1", rs1_data, 32'hDEAD_BEEF);
        check("t2_rs2", rs2_data, 32'h0);

        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        step();
        check("t3_rs1", rs1_data, 32'h0);
        check("t3_rs2", rs2_data, 32'h0);
        check("t3_err", 32'(wr_err), 32'h0);

        drive(32'h0000_0400, 32'h1234_5678, 1'b1, 5'd10, 5'd10);
        step();
        check("t4_byp_rs1", rs1_data, 32'h1234_5678);
        check("t4_byp_rs2", rs2_data, 32'h1234_5678);
        drive(32'h0, 32'h0, 1'b1, 5'd10, 5'd5);
        step();
        check("t4_after_rs1", rs1_data, 32'h1234_5678);
        check("t4_after_rs2", rs2_data, 32'hDEAD_BEEF);

        drive(32'h8000_0000, 32'hCAFE_F00D, 1'b1, 5'd31, 5'd10);
        step();
        check("byp31_rs1", rs1_data, 32'hCAFE_F00D);
        check("byp31_rs2", rs2_data, 32'h1234_5678);

        drive(32'h0000_0002, 32'h1111_1111, 1'b0, 5'd0, 5'd0);
        step();
        drive(32'h0000_0004, 32'h2222_2222, 1'b0, 5'd0, 5'd0);
        step();
        drive(32'h0000_0006, 32'hAAAA_AAAA, 1'b1, 5'd1, 5'd2);
        step();
        check("t5_err", 32'(wr_err), 32'h1);
        check("t5_nobyp_rs1", rs1_data, 32'h1111_1111);
        check("t5_nobyp_rs2", rs2_data, 32'h2222_2222);
        drive(32'h0, 32'h0, 1'b1, 5'd1, 5'd2);
        step();
        check("t5_r1", rs1_data, 32'h1111_1111);
        check("t5_r2", rs2_data, 32'h2222_2222);
        check("t5_sticky", 32'(wr_err), 32'h1);

        drive(32'h0, 32'h0, 1'b0, 5'd5, 5'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold_rs1", rs1_data, 32'h1111_1111);
            check("t6_hold_rs2", rs2_data, 32'h2222_2222);
            check("t6_valid", 32'(rd_valid), 32'h0);
            check("t6_err", 32'(wr_err), 32'h1);
        end
`ifdef RF_DBG_PORT_EN
        dbg_addr = 5'd5;
        #1;
        check("dbg5", dbg_data, 32'hDEAD_BEEF);
        dbg_addr = 5'd0;
        #1;
        check("dbg0", dbg_data, 32'h0);
`endif

        // Reset with a read and a write pending: both dropped, storage cleared.
        rst = 1'b1;
        drive(32'h0000_0020, 32'h5555_5555, 1'b1, 5'd5, 5'd10);
        step();
        check("rst2_valid", 32'(rd_valid), 32'h0);
        check("rst2_rs1", rs1_data, 32'h0);
        check("rst2_err", 32'(wr_err), 32'h0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 5'd5, 5'd10);
        step();
        check("rst2_r5", rs1_data, 32'h0);
        check("rst2_r10", rs2_data, 32'h0);
        check("rst2_valid1", 32'(rd_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
